// File: rtl/router_pkg.sv
// Shared definitions for the router register stage: check-mode constants and
// header field helpers.
package router_pkg;

  localparam int CHK_XOR = 0;
  localparam int CHK_SUM = 1;

  // Header layout is {length, address}; the address occupies the low addr_w bits.
  function automatic logic [31:0] addr_of(input logic [31:0] hdr, input int addr_w);
    return hdr & ((32'd1 << addr_w) - 32'd1);
  endfunction

  function automatic logic [31:0] len_of(input logic [31:0] hdr, input int addr_w);
    return hdr >> addr_w;
  endfunction

endpackage

// File: rtl/router_hold_fifo.sv
// Small order-preserving hold buffer that absorbs bytes while the target
// output FIFO is full.
module router_hold_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH) + 1,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A push into a full buffer is silently ignored; the caller flags overflow.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/router_register_p.sv
// Router input-side register stage: latches the header, forwards bytes to the
// output FIFO write bus, buffers bytes while the FIFO is full and checks packets.
module router_register_p
  import router_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int ADDR_W     = 2,
  parameter  int NUM_PORTS  = 3,
  parameter  int HOLD_DEPTH = 2,
  parameter  int CHK_MODE   = 0,
  localparam int HC_W       = $clog2(HOLD_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              low_pkt_valid,
  output logic              parity_done,
  output logic              err,
  output logic              len_err,
  output logic              ovf_err,
  output logic              addr_invalid,
  output logic              hold_empty,
  output logic [HC_W-1:0]   hold_count
);

  // One extra bit so an over-long packet still differs from the widest length field.
  localparam int CNT_W = DATA_W - ADDR_W + 1;

  logic [DATA_W-1:0] header_q, header_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] chk_byte_q, chk_byte_d;
  logic [CNT_W-1:0]  payload_cnt_q, payload_cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              low_pkt_valid_q, low_pkt_valid_d;
  logic              parity_done_q, parity_done_d;
  logic              eval_q, eval_d;
  logic              err_q, err_d;
  logic              len_err_q, len_err_d;
  logic              ovf_err_q, ovf_err_d;
  logic              addr_invalid_q, addr_invalid_d;
  logic              chk_in_hold_q, chk_in_hold_d;

  logic              hold_push, hold_pop, hold_flush;
  logic              hold_full, hold_empty_w;
  logic [DATA_W-1:0] hold_rd;
  logic [HC_W-1:0]   hold_count_w;
  logic              addr_ok;

  router_hold_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (HOLD_DEPTH)
  ) u_hold (
    .clock   (clock),
    .resetn  (resetn),
    .push    (hold_push),
    .pop     (hold_pop),
    .flush   (hold_flush),
    .wr_data (data_in),
    .rd_data (hold_rd),
    .empty   (hold_empty_w),
    .full    (hold_full),
    .count   (hold_count_w)
  );

  assign addr_ok = (addr_of(32'(data_in), ADDR_W) < 32'(NUM_PORTS));

  always_comb begin
    header_d        = header_q;
    acc_d           = acc_q;
    chk_byte_d      = chk_byte_q;
    payload_cnt_d   = payload_cnt_q;
    dout_d          = dout_q;
    dout_valid_d    = 1'b0;
    low_pkt_valid_d = low_pkt_valid_q;
    parity_done_d   = parity_done_q;
    eval_d          = 1'b0;
    err_d           = err_q;
    len_err_d       = len_err_q;
    ovf_err_d       = ovf_err_q;
    addr_invalid_d  = 1'b0;
    chk_in_hold_d   = chk_in_hold_q;
    hold_push       = 1'b0;
    hold_pop        = 1'b0;
    hold_flush      = 1'b0;

    // Checks run one cycle after parity_done rises, once acc and chk_byte are final.
    if (eval_q) begin
      err_d     = (acc_q != chk_byte_q);
      len_err_d = (32'(payload_cnt_q) != len_of(32'(header_q), ADDR_W));
    end

    if (detect_add) begin
      if (pkt_valid) begin
        if (addr_ok) begin
          header_d        = data_in;
          acc_d           = data_in;
          payload_cnt_d   = '0;
          err_d           = 1'b0;
          len_err_d       = 1'b0;
          ovf_err_d       = 1'b0;
          parity_done_d   = 1'b0;
          low_pkt_valid_d = 1'b0;
          chk_in_hold_d   = 1'b0;
          hold_flush      = 1'b1;
        end else begin
          addr_invalid_d = 1'b1;
        end
      end
    end else if (lfd_state) begin
      dout_d       = header_q;
      dout_valid_d = 1'b1;
    end else if (ld_state) begin
      if (!fifo_full && hold_empty_w) begin
        dout_d       = data_in;
        dout_valid_d = 1'b1;
        if (!pkt_valid) begin
          parity_done_d = 1'b1;
          eval_d        = ~parity_done_q;
        end
      end else begin
        hold_push = 1'b1;
        if (hold_full) ovf_err_d = 1'b1;
        else if (!pkt_valid) chk_in_hold_d = 1'b1;
      end
      if (pkt_valid) begin
        acc_d = (CHK_MODE == CHK_SUM) ? acc_q + data_in : acc_q ^ data_in;
        if (payload_cnt_q != '1) payload_cnt_d = payload_cnt_q + CNT_W'(1);
      end else begin
        chk_byte_d      = data_in;
        low_pkt_valid_d = 1'b1;
      end
    end else if (laf_state) begin
      if (!fifo_full && !hold_empty_w) begin
        hold_pop     = 1'b1;
        dout_d       = hold_rd;
        dout_valid_d = 1'b1;
        // The check byte is always the newest entry, so it leaves last.
        if (chk_in_hold_q && hold_count_w == HC_W'(1)) begin
          parity_done_d = 1'b1;
          eval_d        = ~parity_done_q;
          chk_in_hold_d = 1'b0;
        end
      end
    end

    if (rst_int_reg) low_pkt_valid_d = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header_q        <= '0;
      acc_q           <= '0;
      chk_byte_q      <= '0;
      payload_cnt_q   <= '0;
      dout_q          <= '0;
      dout_valid_q    <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      parity_done_q   <= 1'b0;
      eval_q          <= 1'b0;
      err_q           <= 1'b0;
      len_err_q       <= 1'b0;
      ovf_err_q       <= 1'b0;
      addr_invalid_q  <= 1'b0;
      chk_in_hold_q   <= 1'b0;
    end else begin
      header_q        <= header_d;
      acc_q           <= acc_d;
      chk_byte_q      <= chk_byte_d;
      payload_cnt_q   <= payload_cnt_d;
      dout_q          <= dout_d;
      dout_valid_q    <= dout_valid_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      parity_done_q   <= parity_done_d;
      eval_q          <= eval_d;
      err_q           <= err_d;
      len_err_q       <= len_err_d;
      ovf_err_q       <= ovf_err_d;
      addr_invalid_q  <= addr_invalid_d;
      chk_in_hold_q   <= chk_in_hold_d;
    end
  end

  // full_state is a pure hold condition: every register keeps its value.
  logic unused_full_state;
  assign unused_full_state = full_state;

  assign dout          = dout_q;
  assign dout_valid    = dout_valid_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign parity_done   = parity_done_q;
  assign err           = err_q;
  assign len_err       = len_err_q;
  assign ovf_err       = ovf_err_q;
  assign addr_invalid  = addr_invalid_q;
  assign hold_empty    = hold_empty_w;
  assign hold_count    = hold_count_w;

endmodule

// File: tb/tb_router_register_p.sv
// Randomized and directed bench for router_register_p; an XOR-mode and a sum-mode
// instance share stimulus and are checked against a queue-based packet model.
module tb_router_register_p;

  localparam int HD  = 2;
  localparam int HCW = $clog2(HD) + 1;
  localparam int NP  = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0, fifo_full = 1'b0, detect_add = 1'b0, lfd_state = 1'b0;
  logic       ld_state = 1'b0, laf_state = 1'b0, full_state = 1'b0, rst_int_reg = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0]     dout_x, dout_s;
  logic           dv_x, dv_s, lpv_x, lpv_s, pd_x, pd_s, err_x, err_s;
  logic           le_x, le_s, ovf_x, ovf_s, ai_x, ai_s, he_x, he_s;
  logic [HCW-1:0] hc_x, hc_s;

  always #5 clock = ~clock;

  router_register_p #(.CHK_MODE(0)) dut_x (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout_x), .dout_valid(dv_x),
    .low_pkt_valid(lpv_x), .parity_done(pd_x), .err(err_x), .len_err(le_x),
    .ovf_err(ovf_x), .addr_invalid(ai_x), .hold_empty(he_x), .hold_count(hc_x)
  );

  router_register_p #(.CHK_MODE(1)) dut_s (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout_s), .dout_valid(dv_s),
    .low_pkt_valid(lpv_s), .parity_done(pd_s), .err(err_s), .len_err(le_s),
    .ovf_err(ovf_s), .addr_invalid(ai_s), .hold_empty(he_s), .hold_count(hc_s)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] obs_x[$];
  logic [7:0] obs_s[$];

  always @(negedge clock) begin
    if (dv_x) obs_x.push_back(dout_x);
    if (dv_s) obs_s.push_back(dout_s);
  end

  // Packet-level reference: expected output stream plus hold-buffer contents.
  logic [7:0] m_hdr = 8'h00, m_acc_x = 8'h00, m_acc_s = 8'h00, m_chk = 8'h00;
  int         m_cnt = 0;
  bit         m_ovf = 0, m_pd = 0, m_lpv = 0;
  logic [8:0] m_hold[$];
  logic [7:0] m_exp[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input bit da, input bit lfd, input bit ld, input bit laf,
                      input bit pv, input bit ff, input logic [7:0] d);
    detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
    pkt_valid = pv; fifo_full = ff; data_in = d;
    @(posedge clock); #1;
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    pkt_valid = 0; fifo_full = 0; rst_int_reg = 0;
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic op_hdr(input logic [7:0] hdr);
    tick(1, 0, 0, 0, 1, 0, hdr);
    if (int'(hdr[1:0]) < NP) begin
      m_hdr = hdr; m_acc_x = hdr; m_acc_s = hdr; m_cnt = 0;
      m_ovf = 0; m_pd = 0; m_lpv = 0;
      m_hold.delete(); m_exp.delete(); obs_x.delete(); obs_s.delete();
      check("hdr_clr_err", 32'({err_x, err_s, le_x, ovf_x}), 32'(0));
      check("hdr_clr_pd_lpv", 32'({pd_x, lpv_x}), 32'(0));
      check("hdr_hold_empty", 32'(he_x), 32'(1));
    end else begin
      check("addr_invalid_set", 32'(ai_x), 32'(1));
      idle();
      check("addr_invalid_pulse", 32'(ai_x), 32'(0));
    end
  endtask

  task automatic op_lfd();
    tick(0, 1, 0, 0, 0, 0, 8'h00);
    m_exp.push_back(m_hdr);
    check("lfd_dout", 32'({dv_x, dout_x}), 32'({1'b1, m_hdr}));
  endtask

  task automatic op_ld(input logic [7:0] b, input bit is_chk, input bit ff);
    tick(0, 0, 1, 0, !is_chk, ff, b);
    if (!is_chk) begin
      m_acc_x = m_acc_x ^ b; m_acc_s = m_acc_s + b; m_cnt++;
    end else begin
      m_chk = b; m_lpv = 1;
    end
    if (!ff && m_hold.size() == 0) begin
      m_exp.push_back(b);
      if (is_chk) m_pd = 1;
    end else if (m_hold.size() < HD) begin
      m_hold.push_back({is_chk, b});
    end else begin
      m_ovf = 1;
    end
  endtask

  task automatic op_laf(input bit ff);
    logic [8:0] e;
    tick(0, 0, 0, 1, 0, ff, 8'h00);
    if (!ff && m_hold.size() > 0) begin
      e = m_hold.pop_front();
      m_exp.push_back(e[7:0]);
      if (e[8]) m_pd = 1;
    end
  endtask

  task automatic finish_pkt();
    int n;
    int guard = 0;
    while (m_hold.size() > 0 && guard < 16) begin
      op_laf(guard < 6 ? ($urandom_range(0, 3) == 0) : 1'b0);
      guard++;
    end
    idle(); idle();
    check("stream_len_x", 32'(obs_x.size()), 32'(m_exp.size()));
    check("stream_len_s", 32'(obs_s.size()), 32'(m_exp.size()));
    n = (obs_x.size() < m_exp.size()) ? obs_x.size() : m_exp.size();
    for (int i = 0; i < n; i++) check("stream_byte_x", 32'(obs_x[i]), 32'(m_exp[i]));
    n = (obs_s.size() < m_exp.size()) ? obs_s.size() : m_exp.size();
    for (int i = 0; i < n; i++) check("stream_byte_s", 32'(obs_s[i]), 32'(m_exp[i]));
    check("parity_done", 32'({pd_x, pd_s}), 32'({m_pd, m_pd}));
    check("err_xor", 32'(err_x), 32'(m_pd && (m_acc_x != m_chk)));
    check("err_sum", 32'(err_s), 32'(m_pd && (m_acc_s != m_chk)));
    check("len_err", 32'(le_x), 32'(m_pd && (m_cnt != int'(m_hdr[7:2]))));
    check("ovf_err", 32'(ovf_x), 32'(m_ovf));
    check("low_pkt_valid", 32'(lpv_x), 32'(m_lpv));
    check("hold_empty_end", 32'({he_x, hc_x}), 32'({1'b1, {HCW{1'b0}}}));
    $display("pkt hdr=0x%02h payload=%0d out=%0d ovf=%0d pd=%0d chk=0x%02h acc_x=0x%02h acc_s=0x%02h",
             m_hdr, m_cnt, obs_x.size(), m_ovf, m_pd, m_chk, m_acc_x, m_acc_s);
  endtask

  task automatic xor_pkt(input logic [7:0] chk);
    op_hdr(8'h0D); op_lfd();
    op_ld(8'h11, 0, 0); op_ld(8'h22, 0, 0); op_ld(8'h33, 0, 0);
    op_ld(chk, 1, 0);
    check("pd_with_chk_byte", 32'({dv_x, dout_x, pd_x}), 32'({1'b1, chk, 1'b1}));
    check("err_not_yet", 32'({err_x, err_s}), 32'(0));
    idle();
    check("err_next_cycle_x", 32'(err_x), 32'(chk != 8'h0D));
    check("err_next_cycle_s", 32'(err_s), 32'(chk != 8'h73));
    finish_pkt();
  endtask

  logic [7:0] chk_list [4] = '{8'h0D, 8'h0E, 8'h73, 8'h72};

  initial begin
    int len, addr, npl;
    logic [7:0] hdr, chk;

    #2;
    check("rst_outputs", 32'({dout_x, dv_x, lpv_x, pd_x, err_x, le_x, ovf_x, ai_x, hc_x}), 32'(0));
    check("rst_hold_empty", 32'(he_x), 32'(1));
    @(posedge clock); @(posedge clock); #1;
    resetn = 1'b1;
    idle();

    foreach (chk_list[k]) xor_pkt(chk_list[k]);

    // Two bytes absorbed while the output FIFO is full, then drained in order.
    op_hdr(8'h0D); op_lfd();
    op_ld(8'h11, 0, 0); op_ld(8'h22, 0, 1); op_ld(8'h33, 0, 1);
    check("hold_count_two", 32'({hc_x, he_x}), 32'({HCW'(2), 1'b0}));
    op_laf(0); op_laf(0);
    op_ld(8'h0D, 1, 0);
    finish_pkt();

    // Third push into the full hold buffer is dropped.
    op_hdr(8'h0D); op_lfd();
    op_ld(8'h11, 0, 1); op_ld(8'h22, 0, 1); op_ld(8'h33, 0, 1);
    check("ovf_on_third", 32'(ovf_x), 32'(1));
    op_laf(0); op_laf(0);
    op_ld(8'h0D, 1, 0);
    finish_pkt();

    rst_int_reg = 1'b1;
    idle();
    m_lpv = 0;
    check("rst_int_reg_lpv", 32'({lpv_x, pd_x}), 32'({1'b0, 1'b1}));

    // Bad address leaves the previous header in place.
    op_hdr(8'h0F);
    op_lfd();

    op_hdr(8'h09); op_lfd();
    op_ld(8'h01, 0, 0); op_ld(8'h02, 0, 0); op_ld(8'h03, 0, 0);
    op_ld(8'h0B, 1, 0);
    finish_pkt();
    check("len_err_long", 32'(le_x), 32'(1));

    // Asynchronous reset in the middle of a payload.
    op_hdr(8'h0D); op_lfd();
    op_ld(8'h11, 0, 1); op_ld(8'h22, 0, 1);
    #2 resetn = 1'b0;
    #1;
    check("midrst_outputs", 32'({dout_x, dv_x, lpv_x, pd_x, err_x, le_x, ovf_x, ai_x, hc_x}), 32'(0));
    check("midrst_hold_empty", 32'(he_x), 32'(1));
    @(posedge clock); #1;
    resetn = 1'b1;
    idle();
    xor_pkt(8'h0D);

    for (int p = 0; p < 40; p++) begin
      len  = $urandom_range(0, 5);
      addr = $urandom_range(0, NP - 1);
      hdr  = 8'((len << 2) | addr);
      npl  = len + (($urandom_range(0, 3) == 0) ? 1 : 0);
      op_hdr(hdr); op_lfd();
      for (int i = 0; i < npl; i++) begin
        op_ld(8'($urandom), 0, $urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) == 0) op_laf($urandom_range(0, 3) == 0);
      end
      chk = ($urandom_range(0, 1) == 1) ? m_acc_x : 8'($urandom);
      op_ld(chk, 1, $urandom_range(0, 3) == 0);
      finish_pkt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_register_p.md
Name: router_register_p

Overview:
- Parametrised successor of the router input-side register stage.
- Sits between the input FSM and the per-port output FIFOs. Latches the header, forwards payload bytes and the check byte to the FIFO write bus as dout/dout_valid.
- Absorbs bytes arriving while the target FIFO is full in a small hold buffer.
- Accumulates an XOR parity or additive checksum, checks the payload length against the header length field, and reports check, length, overflow and bad-address errors.

Parameters:
- DATA_W, 8: byte width.
- ADDR_W, 2: header address field width, header[ADDR_W-1:0].
- NUM_PORTS, 3: valid destination addresses are 0..NUM_PORTS-1.
- HOLD_DEPTH, 2: hold-buffer entries (power of 2, at least 1).
- CHK_MODE, 0: 0 = XOR parity; 1 = sum modulo 2^DATA_W.

Ports:
- clock  in  1  clock
- resetn  in  1  reset
- pkt_valid  in  1  source byte is header/payload; low in ld_state marks the check byte
- data_in  in  DATA_W  source byte
- fifo_full  in  1  selected output FIFO full
- detect_add, lfd_state, ld_state, laf_state, full_state  in  1 each  FSM state decodes, at most one high
- rst_int_reg  in  1  clear low_pkt_valid
- dout  out  DATA_W  FIFO write data
- dout_valid  out  1  FIFO write strobe
- low_pkt_valid  out  1  check byte received
- parity_done  out  1  check byte forwarded
- err  out  1  check mismatch
- len_err  out  1  payload count differs from header length
- ovf_err  out  1  hold buffer overflowed, byte dropped
- addr_invalid  out  1  one-cycle pulse, bad header address
- hold_empty  out  1  hold buffer empty
- hold_count  out  clog2(HOLD_DEPTH)+1  hold occupancy

Behaviour:
- Reset: resetn, asynchronous, active-low; clock clock. Every register and output resets to 0, except hold_empty = 1.
- Priority: detect_add > lfd_state > ld_state > laf_state. full_state does nothing; all state is held.
- detect_add & pkt_valid & addr < NUM_PORTS:
  - header <= data_in; acc <= data_in.
  - payload_cnt, err, len_err, ovf_err, parity_done and low_pkt_valid all cleared.
  - hold buffer flushed.
- detect_add & pkt_valid & addr >= NUM_PORTS: addr_invalid = 1 for one cycle; header and acc are unchanged.
- lfd_state: dout <= header, dout_valid = 1.
- ld_state, byte acceptance:
  - Every byte is accepted.
  - If !fifo_full & hold_empty: dout <= data_in, dout_valid = 1.
  - Otherwise the byte is pushed to the hold buffer, which preserves byte order.
  - A push into a full hold buffer drops the byte and sets ovf_err (sticky until the next detect_add).
- ld_state & pkt_valid (payload byte):
  - acc <= acc ^ data_in in mode 0, acc + data_in in mode 1.
  - payload_cnt += 1, saturating at its maximum.
- ld_state & !pkt_valid (check byte):
  - chk_byte <= data_in; low_pkt_valid <= 1.
  - acc is not updated.
- laf_state & !fifo_full & !hold_empty: pop one entry to dout, dout_valid = 1.
- parity_done: set on the edge where the check byte is written to dout (directly or by pop), held until detect_add.
- Error evaluation, on the cycle after parity_done rises; both flags sticky until detect_add:
  - err <= (acc != chk_byte).
  - len_err <= (payload_cnt != header[DATA_W-1:ADDR_W]).
- rst_int_reg: clears low_pkt_valid only.
- dout holds its value whenever dout_valid = 0.
- Latency: a byte accepted with !fifo_full & hold_empty appears on dout/dout_valid one cycle later.

Decomposition:
- Shared package router_pkg: CHK_XOR / CHK_SUM constants and the header field slicing functions (addr_of, len_of).
- Sub-module router_hold_fifo: synchronous FIFO of depth HOLD_DEPTH with push, pop, flush, empty, full and count. Width DATA_W, async active-low reset.

Test Plan:
- XOR packet: header 0x0D (addr 1, len 3), payload 0x11/0x22/0x33, check byte 0x0D, fifo_full = 0.
  - Required: dout sequence 0x0D,0x11,0x22,0x33,0x0D.
  - Required: parity_done = 1; err = 0; len_err = 0.
- Same packet with check byte 0x0E -> err = 1 one cycle after parity_done; err clears at the next detect_add.
- CHK_MODE = 1, same packet, check byte 0x73 -> err = 0. Check byte 0x72 -> err = 1.
- fifo_full high while 0x22 and 0x33 arrive (HOLD_DEPTH = 2):
  - Required: hold_count = 2.
  - In laf_state with fifo_full low, 0x22 then 0x33 pop in order, followed by the check byte, and the dout order is intact.
  - A third byte pushed while full -> ovf_err = 1.
- Header 0x0F (addr 3) -> addr_invalid pulses for 1 cycle and header is unchanged. Header 0x09 (len 2) followed by 3 payload bytes -> len_err = 1.
- resetn low mid-payload -> all outputs 0 immediately and hold_empty = 1. A following packet processes normally.
